// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Purpose  : Start/operand/result bundle between the control FSM and div_unit.
//  Revision : 1.0  initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_end;
    logic             div_zero;
    logic             busy;

    modport master (
        output div_ctrl, a, b,
        input  hi_out, lo_out, div_end, div_zero, busy
    );

    modport slave (
        input  div_ctrl, a, b,
        output hi_out, lo_out, div_end, div_zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Multi-cycle signed restoring divider (MIPS DIV), quotient to LO,
//             remainder to HI, one quotient bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic  clock,
    input  wire logic  reset,
    div_unit_if.slave  bus
);

    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_div_ctrl_q;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH:0]     r_dsr;
    logic [WIDTH:0]     r_rem;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_end;
    logic               r_div_zero;
    logic               r_busy;

    logic               w_start;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_mag;

    assign w_start   = bus.div_ctrl & ~r_div_ctrl_q;
    // Magnitudes are taken as unsigned WIDTH-bit values, so |most-negative| is exact.
    assign w_abs_a   = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
    assign w_abs_b   = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
    assign w_rem_sh  = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    // A set top bit would be shifted out, so the shifted value surely exceeds the divisor.
    assign w_ge      = r_rem[WIDTH] | (w_rem_sh >= r_dsr);
    assign w_diff    = w_rem_sh - r_dsr;
    assign w_rem_mag = r_rem[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_div_ctrl_q <= 1'b0;
            r_dvd        <= '0;
            r_dsr        <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_sign_q     <= 1'b0;
            r_sign_r     <= 1'b0;
            r_zero       <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_div_end    <= 1'b0;
            r_div_zero   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_div_ctrl_q <= bus.div_ctrl;
            r_div_end    <= 1'b0;
            r_div_zero   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_busy <= 1'b1;
                        if (bus.b == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_zero   <= 1'b0;
                            r_dvd    <= w_abs_a;
                            r_dsr    <= {1'b0, w_abs_b};
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            r_sign_r <= bus.a[WIDTH-1];
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_ge ? w_diff : w_rem_sh;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= r_sign_q ? (-r_dvd) : r_dvd;
                    r_hi    <= r_sign_r ? (-w_rem_mag) : w_rem_mag;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_div_end  <= 1'b1;
                    r_div_zero <= r_zero;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi_out   = r_hi;
    assign bus.lo_out   = r_lo;
    assign bus.div_end  = r_div_end;
    assign bus.div_zero = r_div_zero;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Scoreboard bench for div_unit: results queued at start, checked
//             on every div_end pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    localparam int c_width = 32;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        int          start;
        int          lat;
    } exp_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   n_end;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    exp_t sb[$];

    div_unit_if #(.WIDTH(c_width)) bus ();

    div_unit #(.WIDTH(c_width)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int start);
        exp_t   e;
        longint sa;
        longint sd;
        longint q;
        longint r;
        e.start = start;
        if (b == 32'd0) begin
            e.zero = 1'b1;
            e.lo   = m_lo;
            e.hi   = m_hi;
            e.lat  = 1;
        end else begin
            sa     = longint'($signed(a));
            sd     = longint'($signed(b));
            q      = sa / sd;
            r      = sa % sd;
            e.zero = 1'b0;
            e.lo   = q[31:0];
            e.hi   = r[31:0];
            e.lat  = c_width + 2;
        end
        return e;
    endfunction

    // Monitor: every div_end pulse must match the oldest queued expectation.
    always @(posedge clock) begin
        exp_t e;
        #1;
        cyc++;
        if (bus.div_end === 1'b1) begin
            n_end++;
            if (sb.size() == 0) begin
                check("spurious_div_end", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("lo", bus.lo_out, e.lo);
                check("hi", bus.hi_out, e.hi);
                check("div_zero", 32'(bus.div_zero), 32'(e.zero));
                check("latency", 32'(cyc - e.start), 32'(e.lat));
                check("busy_at_end", 32'(bus.busy), 32'd1);
            end
        end else if (bus.div_zero !== 1'b0) begin
            check("div_zero_alone", 32'(bus.div_zero), 32'd0);
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(a, b, cyc + 1);
        sb.push_back(e);
        if (!e.zero) begin
            m_lo = e.lo;
            m_hi = e.hi;
        end
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input bit expect_result);
        @(negedge clock);
        bus.div_ctrl = 1'b0;
        @(negedge clock);
        bus.a        = a;
        bus.b        = b;
        bus.div_ctrl = 1'b1;
        if (expect_result) push_exp(a, b);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clock);
        bus.div_ctrl = 1'b0;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        start_div(a, b, 1'b1);
        drain();
    endtask

    initial begin
        int ends0;
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        n_end        = 0;
        m_hi         = '0;
        m_lo         = '0;
        reset        = 1'b0;
        bus.div_ctrl = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(negedge clock);
        check("rst_hi", bus.hi_out, 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        check("rst_div_end", 32'(bus.div_end), 32'd0);
        check("rst_div_zero", 32'(bus.div_zero), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;

        run_div(32'd100, 32'd7);
        run_div(32'd5, 32'd0);
        run_div(32'hFFFF_FFF9, 32'd2);
        run_div(32'd7, 32'hFFFF_FFFE);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'h8000_0000, 32'd1);
        run_div(32'h8000_0000, 32'h8000_0000);
        run_div(32'hFFFF_FFFF, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            run_div($urandom, $urandom_range(1, 1000));
        end

        // Level held high for 100 cycles produces a single division.
        ends0 = n_end;
        start_div(32'd1234, 32'd56, 1'b1);
        repeat (100) @(negedge clock);
        bus.div_ctrl = 1'b0;
        drain();
        check("hold_one_end", 32'(n_end - ends0), 32'd1);

        // A second rising edge during RUN is ignored, not queued.
        ends0 = n_end;
        start_div(32'd1000, 32'd10, 1'b1);
        repeat (5) @(negedge clock);
        bus.div_ctrl = 1'b0;
        @(negedge clock);
        bus.div_ctrl = 1'b1;
        @(negedge clock);
        bus.div_ctrl = 1'b0;
        drain();
        repeat (40) @(negedge clock);
        check("toggle_one_end", 32'(n_end - ends0), 32'd1);
        run_div(32'hFFFF_FC18, 32'd3);

        // Asynchronous reset at RUN step 10 aborts without a div_end.
        ends0 = n_end;
        start_div(32'd123456, 32'd7, 1'b0);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("abort_hi", bus.hi_out, 32'd0);
        check("abort_lo", bus.lo_out, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_div_end", 32'(bus.div_end), 32'd0);
        m_hi = '0;
        m_lo = '0;
        bus.a        = 32'd9;
        bus.b        = 32'd3;
        bus.div_ctrl = 1'b1;
        repeat (3) @(negedge clock);
        // div_ctrl already high at the first edge after release counts as a start.
        reset = 1'b1;
        push_exp(32'd9, 32'd3);
        drain();
        check("abort_no_end", 32'(n_end - ends0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
